// File: rtl/manchester_rx.sv
// Manchester receiver: syncs the line, locks onto preamble/SFD and writes decoded bytes (w_en 4 clocks after the byte's last mid-bit wire edge).
// No backpressure: full sampled in the write slot aborts the frame with err and drains the rest.
module manchester_rx #(
  parameter int         HALF_BIT    = 5,
  parameter int         MAX_BYTES   = 1518,
  parameter logic [7:0] SFD_PATTERN = 8'hAB
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Ethernet_In,
  input  logic       full,
  output logic [7:0] w_data,
  output logic       w_en,
  output logic       eop,
  output logic       err,
  output logic       busy
);
  localparam int             CW       = $clog2(3*HALF_BIT + 1);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(3*HALF_BIT);
  localparam logic [CW-1:0]  ACC_LO   = CW'(2*HALF_BIT - 2);
  localparam logic [CW-1:0]  ACC_HI   = CW'(3*HALF_BIT - 1);
  localparam logic [10:0]    BYTE_MAX = 11'(MAX_BYTES);

  typedef enum logic [2:0] {IDLE, ACQ, HUNT, DATA, DRAIN} state_t;
  state_t state, state_nxt;

  logic          sync1, sync2, line_q;
  logic          edge_any, edge_rise, accept, timeout, anchor;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0]    hunt_sr, hunt_nxt, data_sr, data_nxt, w_data_nxt;
  logic [2:0]    bit_cnt, bit_nxt;
  logic [10:0]   byte_cnt, byte_nxt;
  logic          byte_rdy, byte_rdy_nxt, w_en_nxt, eop_nxt, err_nxt;

  // Synchronizer resets to the idle-high level so reset release is not seen as an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      line_q <= 1'b1;
    end else begin
      sync1  <= Ethernet_In;
      sync2  <= sync1;
      line_q <= sync2;
    end
  end

  assign edge_any  = sync2 ^ line_q;
  assign edge_rise = sync2 & ~line_q;
  assign accept    = edge_any && (cnt >= ACC_LO) && (cnt <= ACC_HI);
  // Fires on the clock where cnt would reach CNT_MAX; an edge at ACC_HI always anchors instead.
  assign timeout   = (cnt == ACC_HI) && !edge_any;
  assign cnt_nxt   = anchor ? '0 : ((cnt == CNT_MAX) ? cnt : cnt + 1'b1);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt    = state;
    anchor       = 1'b0;
    hunt_nxt     = hunt_sr;
    data_nxt     = data_sr;
    bit_nxt      = bit_cnt;
    byte_nxt     = byte_cnt;
    byte_rdy_nxt = 1'b0;
    w_data_nxt   = w_data;
    w_en_nxt     = 1'b0;
    eop_nxt      = 1'b0;
    err_nxt      = 1'b0;
    unique case (state)
      IDLE: if (edge_any) begin
        anchor    = 1'b1;
        hunt_nxt  = '0;
        state_nxt = ACQ;
      end
      ACQ: if (edge_any && cnt != '0) begin
        anchor    = 1'b1;
        hunt_nxt  = {hunt_sr[6:0], edge_rise};
        state_nxt = HUNT;
      end else if (timeout) begin
        state_nxt = IDLE;
      end
      HUNT: if (accept) begin
        anchor   = 1'b1;
        hunt_nxt = {hunt_sr[6:0], edge_rise};
        if ({hunt_sr[6:0], edge_rise} == SFD_PATTERN) begin
          state_nxt = DATA;
          bit_nxt   = '0;
          byte_nxt  = '0;
        end
      end else if (timeout) begin
        state_nxt = IDLE;
      end
      DATA: if (byte_rdy) begin
        if (full || byte_cnt == BYTE_MAX) begin
          err_nxt   = 1'b1;
          state_nxt = DRAIN;
        end else begin
          w_en_nxt   = 1'b1;
          w_data_nxt = data_sr;
          byte_nxt   = byte_cnt + 11'd1;
        end
      end else if (accept) begin
        anchor       = 1'b1;
        data_nxt     = {data_sr[6:0], edge_rise};
        bit_nxt      = bit_cnt + 3'd1;
        byte_rdy_nxt = (bit_cnt == 3'd7);
      end else if (timeout) begin
        if (bit_cnt == 3'd0 && byte_cnt != '0) eop_nxt = 1'b1;
        else                                   err_nxt = 1'b1;
        state_nxt = IDLE;
      end
      DRAIN: if (edge_any) begin
        anchor = 1'b1;
      end else if (timeout) begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      hunt_sr  <= '0;
      data_sr  <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      byte_rdy <= 1'b0;
      w_data   <= '0;
      w_en     <= 1'b0;
      eop      <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      hunt_sr  <= hunt_nxt;
      data_sr  <= data_nxt;
      bit_cnt  <= bit_nxt;
      byte_cnt <= byte_nxt;
      byte_rdy <= byte_rdy_nxt;
      w_data   <= w_data_nxt;
      w_en     <= w_en_nxt;
      eop      <= eop_nxt;
      err      <= err_nxt;
    end
  end
endmodule

// File: tb/tb_manchester_rx.sv
// Bench for manchester_rx: Manchester frame driver, event monitor and frame-level expected-event model.
module tb_manchester_rx;
  localparam int HALF  = 5;
  // Small frame limit keeps the oversize frame short.
  localparam int MAX_B = 40;
  localparam int KWR = 0, KEOP = 1, KERR = 2;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] dat;
  } ev_t;

  logic       clk, rst, ser, full;
  logic [7:0] w_data;
  logic       w_en, eop, err, busy;

  int   cyc = 0, checks = 0, errors = 0, multi = 0;
  int   busy_fall = -1, last_tr = 0;
  logic busy_prev = 1'b0;
  bit   rec = 1'b0;
  int   mids[$];
  ev_t  actq[$], expq[$];

  manchester_rx #(.HALF_BIT(HALF), .MAX_BYTES(MAX_B), .SFD_PATTERN(8'hAB)) dut (
    .clk(clk), .rst(rst), .Ethernet_In(ser), .full(full),
    .w_data(w_data), .w_en(w_en), .eop(eop), .err(err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (w_en) actq.push_back('{cyc, KWR, w_data});
      if (eop)  actq.push_back('{cyc, KEOP, 8'h00});
      if (err)  actq.push_back('{cyc, KERR, 8'h00});
      if (int'(w_en) + int'(eop) + int'(err) > 1) multi++;
      if (busy_prev && !busy) busy_fall = cyc;
      busy_prev = busy;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_line(input logic v);
    if (ser !== v) last_tr = cyc;
    ser = v;
  endtask

  // 1 = low-then-high, 0 = high-then-low; mid-bit wire transition times are recorded.
  task automatic send_bit(input logic b);
    set_line(!b);
    repeat (HALF) tick();
    set_line(b);
    if (rec) mids.push_back(cyc);
    repeat (HALF) tick();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_header();
    mids.delete();
    rec = 1'b0;
    repeat (7) send_byte(8'hAA);
    send_byte(8'hAB);
    rec = 1'b1;
  endtask

  // Expected events of one frame: each byte written 4 clocks after its 8th mid-bit transition
  // unless full or the size limit hits that slot (err, frame over); otherwise eop, or err when
  // the frame ends mid-byte, 15 clocks after the last mid-bit edge becomes visible (3 clocks).
  task automatic model(input logic [7:0] q[$], input int full_at, input int trunc);
    for (int k = 0; k < q.size(); k++) begin
      int t;
      t = mids[8*k+7] + 4;
      if (k == full_at || k >= MAX_B) begin
        expq.push_back('{t, KERR, 8'h00});
        return;
      end
      expq.push_back('{t, KWR, q[k]});
    end
    expq.push_back('{mids[mids.size()-1] + 18, (trunc > 0) ? KERR : KEOP, 8'h00});
  endtask

  task automatic run_frame(input logic [7:0] q[$], input int full_at, input int trunc);
    logic [7:0] tb;
    send_header();
    for (int k = 0; k < q.size(); k++) begin
      if (k == full_at) full = 1'b1;
      send_byte(q[k]);
    end
    tb = 8'($urandom);
    for (int i = 0; i < trunc; i++) send_bit(tb[7-i]);
    rec = 1'b0;
    set_line(1'b1);
    model(q, full_at, trunc);
  endtask

  task automatic settle();
    repeat (40) tick();
    chk("idle_busy", int'(busy), 0);
    full = 1'b0;
  endtask

  task automatic compare(input string tag);
    chk({tag, "_nev"}, actq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < actq.size(); i++) begin
      chk({tag, "_kind"}, actq[i].kind, expq[i].kind);
      chk({tag, "_cyc"},  actq[i].cyc,  expq[i].cyc);
      chk({tag, "_dat"},  int'(actq[i].dat), int'(expq[i].dat));
    end
    actq.delete();
    expq.delete();
  endtask

  function automatic void good_frame(output logic [7:0] q[$]);
    q = {};
    for (int i = 0; i < 22; i++) q.push_back((i >= 14 && i <= 17) ? 8'h0F : 8'hFB);
  endfunction

  initial begin
    logic [7:0] q[$];
    logic [7:0] fb;
    int rise, n, fa, tr;
    rst = 1'b1; ser = 1'b1; full = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outs", int'({w_data, w_en, eop, err, busy}), 0);
    tick();
    rst = 1'b0;
    repeat (20) tick();
    chk("reset_idle_busy", int'(busy), 0);

    good_frame(q);
    busy_fall = -1;
    run_frame(q, -1, 0);
    settle();
    chk("good_busy_fall", busy_fall, mids[mids.size()-1] + 18);
    compare("good");

    for (int f = 0; f < 3; f++) begin
      good_frame(q);
      if (f == 1) for (int i = 6; i <= 11; i++) q[i] = 8'hA3;
      run_frame(q, -1, 0);
      repeat (20) tick();
    end
    settle();
    compare("b2b");

    good_frame(q);
    busy_fall = -1;
    run_frame(q, 2, 0);
    settle();
    chk("ovf_busy_fall", busy_fall, last_tr + 18);
    compare("ovf");

    q = {};
    for (int i = 0; i < MAX_B + 4; i++) q.push_back(8'($urandom));
    run_frame(q, -1, 0);
    settle();
    compare("oversize");

    q = {8'hFB, 8'h5C};
    run_frame(q, -1, 4);
    settle();
    compare("trunc");

    busy_fall = -1;
    set_line(1'b0);
    repeat (2) tick();
    set_line(1'b1);
    rise = cyc;
    repeat (30) tick();
    chk("glitch_busy_fall", int'(busy_fall > rise && busy_fall - rise <= 20), 1);
    compare("glitch");

    fb = 8'hFB;
    send_header();
    repeat (4) send_byte(fb);
    for (int i = 7; i >= 4; i--) send_bit(fb[i]);
    fork
      begin
        @(negedge clk);
        chk("rst_mid_outs", int'({w_data, w_en, eop, err, busy}), 0);
        @(posedge clk);
        #1 rst = 1'b0;
      end
    join_none
    rst = 1'b1;
    for (int i = 3; i >= 0; i--) send_bit(fb[i]);
    rec = 1'b0;
    set_line(1'b1);
    for (int k = 0; k < 4; k++) expq.push_back('{mids[8*k+7] + 4, KWR, fb});
    settle();
    compare("rst_mid");
    good_frame(q);
    run_frame(q, -1, 0);
    settle();
    compare("after_rst");

    for (int r = 0; r < 10; r++) begin
      n  = $urandom_range(1, 10);
      q  = {};
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      fa = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
      tr = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      run_frame(q, fa, tr);
      settle();
      compare("rand");
    end

    chk("one_hot", multi, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
